bch_syndrome_calc: RTL and testbench



---
 rtl/bch_syndrome_calc.sv | 140 ++++++++++++++
 tb/tb_bch_syndrome_calc.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bch_syndrome_calc.sv
// Purpose : serial BCH syndrome calculator over GF(2^M); computes S_1..S_2T of one received frame.
// Latency : one bit per cycle in ACCUM; syndromes valid on the cycle after the final bit is accepted.
// Backpr. : in_ready is low while a result is held; the result stays frozen until s_valid & s_ready.
//
// Ports:
//   clk, rstn          sole clock, asynchronous active-low reset
//   flush              synchronous abort: clears the frame/result, discards a same-cycle bit
//   in_valid/in_ready  bit handshake; in_bit is the coefficient, x^(N-1) first
//   in_last            marks the final bit of a frame (a frame also ends after N bits)
//   s_valid/s_ready    result handshake
//   syndromes          S_j in [j*M-1:(j-1)*M], j = 1..2T
//   err_detect         any S_j non-zero
//   len_err            frame length was not N
module bch_syndrome_calc #(
    parameter int         M         = 4,
    parameter int         T         = 2,
    parameter logic [M:0] PRIM_POLY = 5'b10011
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [2*T*M-1:0] syndromes,
    output logic             err_detect,
    output logic             len_err
);

    localparam int N  = (1 << M) - 1;
    localparam int CW = $clog2(N);
    localparam int NS = 2 * T;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    // Multiply by alpha^p: p successive shifts, each folding the overflowing
    // x^M term back in through the primitive polynomial. With p constant per
    // instance this collapses into a fixed XOR network.
    function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] x, input int p);
        logic [M-1:0] acc;
        acc = x;
        for (int i = 0; i < p; i++) begin
            acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? PRIM_POLY[M-1:0] : {M{1'b0}});
        end
        return acc;
    endfunction

    state_t                 state_q;
    state_t                 state_d;
    logic                   armed_q;
    logic [CW-1:0]          count_q;
    logic [NS-1:0][M-1:0]   synd_q;
    logic [NS-1:0][M-1:0]   synd_nxt;
    logic                   err_q;
    logic                   len_err_q;

    logic accept;
    logic at_last_idx;
    logic frame_end;

    // armed_q keeps in_ready low until the first edge after reset release.
    assign in_ready    = armed_q && (state_q == ACCUM);
    assign s_valid     = (state_q == OUT);
    assign accept      = in_valid && in_ready;
    assign at_last_idx = (count_q == LAST_IDX);
    assign frame_end   = accept && (in_last || at_last_idx);

    assign syndromes  = synd_q;
    assign err_detect = err_q;
    assign len_err    = len_err_q;

    // Horner step per syndrome: S_j <- S_j * alpha^j + r_i.
    for (genvar j = 1; j <= NS; j++) begin : g_synd
        assign synd_nxt[j-1] = mul_alpha_pow(synd_q[j-1], j) ^ {{(M-1){1'b0}}, in_bit};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: if (frame_end) state_d = OUT;
                OUT:   if (s_ready)   state_d = ACCUM;
                default:              state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed_q   <= 1'b0;
            count_q   <= '0;
            synd_q    <= '0;
            err_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (flush) begin
                count_q   <= '0;
                synd_q    <= '0;
                err_q     <= 1'b0;
                len_err_q <= 1'b0;
            end else if (state_q == OUT) begin
                // Result is frozen until consumed; in_valid is ignored here.
                if (s_ready) begin
                    count_q   <= '0;
                    synd_q    <= '0;
                    err_q     <= 1'b0;
                    len_err_q <= 1'b0;
                end
            end else if (accept) begin
                synd_q  <= synd_nxt;
                count_q <= count_q + CW'(1);
                if (frame_end) begin
                    err_q     <= |synd_nxt;
                    // Only in_last landing exactly on bit N is a correct length.
                    len_err_q <= !(in_last && at_last_idx);
                end
            end
        end
    end

endmodule

// File: tb/tb_bch_syndrome_calc.sv
module tb_bch_syndrome_calc;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        in_last;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] syndromes;
    logic        err_detect;
    logic        len_err;

    int checks = 0;
    int errors = 0;

    bch_syndrome_calc #(
        .M         (4),
        .T         (2),
        .PRIM_POLY (5'b10011)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .in_last    (in_last),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .syndromes  (syndromes),
        .err_detect (err_detect),
        .len_err    (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends the first nbits of vec, vec[14] first; called and returns at a negedge.
    task automatic send_bits(input logic [14:0] vec, input int nbits, input bit with_last);
        for (int i = 0; i < nbits; i++) begin
            check("in_ready_per_bit", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_bit   = vec[14-i];
            in_last  = with_last && (i == nbits - 1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [15:0] exp_s, input bit exp_err, input bit exp_len);
        check({tag, "_s_valid"},  64'(s_valid),    64'd1);
        check({tag, "_in_ready"}, 64'(in_ready),   64'd0);
        check({tag, "_synd"},     64'(syndromes),  64'(exp_s));
        check({tag, "_err"},      64'(err_detect), 64'(exp_err));
        check({tag, "_len_err"},  64'(len_err),    64'(exp_len));
    endtask

    task automatic accept_out();
        s_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_ready = 1'b0;
        check("hs_s_valid",  64'(s_valid),    64'd0);
        check("hs_in_ready", 64'(in_ready),   64'd1);
        check("hs_synd",     64'(syndromes),  64'd0);
        check("hs_err",      64'(err_detect), 64'd0);
        check("hs_len_err",  64'(len_err),    64'd0);
    endtask

    initial begin
        rstn     = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
        s_ready  = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready),   64'd0);
        check("rst_s_valid",  64'(s_valid),    64'd0);
        check("rst_synd",     64'(syndromes),  64'd0);
        check("rst_err",      64'(err_detect), 64'd0);
        check("rst_len_err",  64'(len_err),    64'd0);

        rstn = 1'b1;
        check("rel_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("rel_in_ready_high", 64'(in_ready), 64'd1);

        // All-zero codeword, in_last on bit 15.
        send_bits(15'h0000, 15, 1'b1);
        check_out("zero", 16'h0000, 1'b0, 1'b0);
        accept_out();

        // Generator polynomial x^8+x^7+x^6+x^4+1 is itself a codeword.
        send_bits(15'h01D1, 15, 1'b1);
        check_out("gen", 16'h0000, 1'b0, 1'b0);
        accept_out();

        // r(x)=x: S_j = alpha^j -> S4..S1 = 0011 1000 0100 0010.
        send_bits(15'h0002, 15, 1'b1);
        check_out("rx_x", 16'h3842, 1'b1, 1'b0);
        accept_out();

        // r(x)=1: every S_j = 1.
        send_bits(15'h0001, 15, 1'b1);
        check_out("rx_1", 16'h1111, 1'b1, 1'b0);
        accept_out();

        // r(x)=x^14: S1=alpha^14=1001, S2=alpha^13=1101, S3=alpha^12=1111, S4=alpha^11=1110.
        send_bits(15'h4000, 15, 1'b1);
        check_out("rx_x14", 16'hEFD9, 1'b1, 1'b0);
        accept_out();

        // Short frame: in_last on bit 10.
        send_bits(15'h0000, 10, 1'b1);
        check_out("short", 16'h0000, 1'b0, 1'b1);
        accept_out();

        // 15 bits without in_last: frame closes at bit 15 with len_err.
        send_bits(15'h0000, 15, 1'b0);
        check_out("no_last", 16'h0000, 1'b0, 1'b1);
        accept_out();

        // Backpressure: s_ready low for 5 cycles while in_valid toggles.
        send_bits(15'h0002, 15, 1'b1);
        check_out("bp_start", 16'h3842, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            in_bit   = 1'b1;
            in_last  = (k == 2);
            @(posedge clk);
            @(negedge clk);
            check_out("bp_hold", 16'h3842, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
        accept_out();

        // Flush at bit 7: the bit presented with flush is discarded.
        send_bits(15'h7FFF, 7, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        check("flush_in_ready", 64'(in_ready),  64'd1);
        check("flush_s_valid",  64'(s_valid),   64'd0);
        check("flush_synd",     64'(syndromes), 64'd0);
        send_bits(15'h0000, 15, 1'b1);
        check_out("after_flush", 16'h0000, 1'b0, 1'b0);
        accept_out();

        // Reset pulse at bit 7.
        send_bits(15'h7FFF, 7, 1'b0);
        rstn = 1'b0;
        #1;
        check("mid_rst_synd",     64'(syndromes), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready),  64'd0);
        check("mid_rst_s_valid",  64'(s_valid),   64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("mid_rst_rearm", 64'(in_ready), 64'd1);
        send_bits(15'h0000, 15, 1'b1);
        check_out("after_rst", 16'h0000, 1'b0, 1'b0);
        accept_out();

        // Reset while a result is pending: result is dropped.
        send_bits(15'h0002, 15, 1'b1);
        check_out("pend", 16'h3842, 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        check("pend_rst_s_valid", 64'(s_valid),    64'd0);
        check("pend_rst_synd",    64'(syndromes),  64'd0);
        check("pend_rst_err",     64'(err_detect), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("pend_rst_rearm", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
